// File: rtl/jam_assign_engine.sv
// Exhaustive N-worker/N-job assignment solver: walks every permutation in
// lexicographic order and reports the best total, its multiplicity and first optimum.
module jam_assign_engine #(
    parameter int N      = 8,
    parameter int COST_W = 7,
    parameter int CNT_W  = 16,
    parameter int PRUNE  = 1,
    localparam int IDX_W = $clog2(N),
    localparam int SUM_W = COST_W + $clog2(N) + 1
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 start,
    input  logic                 max_mode,
    input  logic [COST_W-1:0]    Cost,
    output logic [IDX_W-1:0]     W,
    output logic [IDX_W-1:0]     J,
    output logic                 busy,
    output logic                 Valid,
    output logic [SUM_W-1:0]     MinCost,
    output logic [CNT_W-1:0]     MatchCount,
    output logic [N*IDX_W-1:0]   BestPerm
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_EVAL = 3'd2,
        S_NEXT = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t               state_r, state_nxt;
    logic [IDX_W-1:0]     k_r;
    logic [IDX_W-1:0]     p_r [N];
    logic [IDX_W-1:0]     p_nxt_s [N];
    logic [IDX_W-1:0]     sw_s [N];
    logic [SUM_W-1:0]     total_r;
    logic                 mode_r;
    logic [SUM_W-1:0]     min_r;
    logic [CNT_W-1:0]     cnt_r;
    logic [N*IDX_W-1:0]   best_r;
    logic                 busy_r;
    logic                 valid_r;

    logic [SUM_W-1:0]     sum_s;
    logic                 prune_s;
    logic                 last_k_s;
    logic                 is_last_s;
    logic                 better_s;
    logic [N*IDX_W-1:0]   p_flat_s;
    logic [IDX_W-1:0]     j_sel_s;
    logic                 found_s;
    int                   piv_s;
    int                   jj_s;
    logic [IDX_W-1:0]     pv_s;
    logic [IDX_W-1:0]     qv_s;

    assign sum_s     = total_r + SUM_W'(Cost);
    assign last_k_s  = (k_r == IDX_W'(N - 1));
    assign is_last_s = ~found_s;
    assign better_s  = mode_r ? (total_r > min_r) : (total_r < min_r);
    // Only a permutation that is already worse than a known optimum may be cut short.
    assign prune_s   = (PRUNE != 0) && !mode_r && (cnt_r != '0) && (sum_s > min_r);

    assign W          = (state_r == S_LOAD) ? k_r : '0;
    assign J          = (state_r == S_LOAD) ? j_sel_s : '0;
    assign busy       = busy_r;
    assign Valid      = valid_r;
    assign MinCost    = min_r;
    assign MatchCount = cnt_r;
    assign BestPerm   = best_r;

    // Flatten the permutation and select the job for the current worker.
    always_comb begin
        p_flat_s = '0;
        j_sel_s  = '0;
        for (int i = 0; i < N; i++) begin
            p_flat_s[i*IDX_W +: IDX_W] = p_r[i];
            if (k_r == IDX_W'(i)) begin
                j_sel_s = p_r[i];
            end else begin
                j_sel_s = j_sel_s;
            end
        end
    end

    // Single-cycle next lexicographic permutation: pivot, swap, reverse suffix.
    always_comb begin
        piv_s   = 0;
        found_s = 1'b0;
        pv_s    = '0;
        jj_s    = 0;
        qv_s    = '0;
        for (int i = 0; i < N - 1; i++) begin
            if (p_r[i] < p_r[i+1]) begin
                piv_s   = i;
                found_s = 1'b1;
            end else begin
                piv_s = piv_s;
            end
        end
        for (int i = 0; i < N; i++) begin
            if (i == piv_s) pv_s = p_r[i];
            else            pv_s = pv_s;
        end
        // The suffix is descending, so the largest index above the pivot value wins.
        for (int i = 0; i < N; i++) begin
            if (p_r[i] > pv_s) jj_s = i;
            else               jj_s = jj_s;
        end
        for (int i = 0; i < N; i++) begin
            if (i == jj_s) qv_s = p_r[i];
            else           qv_s = qv_s;
        end
        for (int m = 0; m < N; m++) begin
            if (m == piv_s)     sw_s[m] = qv_s;
            else if (m == jj_s) sw_s[m] = pv_s;
            else                sw_s[m] = p_r[m];
        end
        for (int m = 0; m < N; m++) begin
            p_nxt_s[m] = sw_s[m];
            if (m > piv_s) begin
                for (int s = 0; s < N; s++) begin
                    if (s == N + piv_s - m) p_nxt_s[m] = sw_s[s];
                    else                    p_nxt_s[m] = p_nxt_s[m];
                end
            end else begin
                p_nxt_s[m] = sw_s[m];
            end
        end
    end

    // State register.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state_r <= S_IDLE;
        else     state_r <= state_nxt;
    end

    // Next-state decode.
    always_comb begin
        state_nxt = state_r;
        case (state_r)
            S_IDLE: begin
                if (start) state_nxt = S_LOAD;
                else       state_nxt = S_IDLE;
            end
            S_LOAD: begin
                if (prune_s)       state_nxt = is_last_s ? S_DONE : S_NEXT;
                else if (last_k_s) state_nxt = S_EVAL;
                else               state_nxt = S_LOAD;
            end
            S_EVAL: begin
                if (is_last_s) state_nxt = S_DONE;
                else           state_nxt = S_NEXT;
            end
            S_NEXT:  state_nxt = S_LOAD;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Datapath: permutation, running total, best-so-far results and handshake.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            k_r     <= '0;
            total_r <= '0;
            mode_r  <= 1'b0;
            min_r   <= '1;
            cnt_r   <= '0;
            busy_r  <= 1'b0;
            valid_r <= 1'b0;
            for (int i = 0; i < N; i++) begin
                p_r[i]                   <= IDX_W'(i);
                best_r[i*IDX_W +: IDX_W] <= IDX_W'(i);
            end
        end else begin
            valid_r <= (state_nxt == S_DONE);
            if (state_nxt == S_DONE) busy_r <= 1'b0;
            else if (state_r == S_IDLE && start) busy_r <= 1'b1;
            else busy_r <= busy_r;
            case (state_r)
                S_IDLE: begin
                    if (start) begin
                        k_r     <= '0;
                        total_r <= '0;
                        mode_r  <= max_mode;
                        min_r   <= max_mode ? '0 : '1;
                        cnt_r   <= '0;
                        for (int i = 0; i < N; i++) p_r[i] <= IDX_W'(i);
                    end else begin
                        k_r <= k_r;
                    end
                end
                S_LOAD: begin
                    total_r <= sum_s;
                    if (prune_s || last_k_s) k_r <= '0;
                    else                     k_r <= k_r + IDX_W'(1);
                end
                S_EVAL: begin
                    // The first scored permutation always seeds the result.
                    if (cnt_r == '0 || better_s) begin
                        min_r  <= total_r;
                        cnt_r  <= CNT_W'(1);
                        best_r <= p_flat_s;
                    end else if (total_r == min_r) begin
                        cnt_r <= cnt_r + CNT_W'(1);
                    end else begin
                        cnt_r <= cnt_r;
                    end
                end
                S_NEXT: begin
                    total_r <= '0;
                    k_r     <= '0;
                    for (int i = 0; i < N; i++) p_r[i] <= p_nxt_s[i];
                end
                S_DONE:  k_r <= '0;
                default: k_r <= '0;
            endcase
        end
    end

endmodule

// File: tb/tb_jam_assign_engine.sv
// Directed and randomised checks of jam_assign_engine against an exhaustive
// tuple-enumeration reference model, on four parameterisations sharing one clock.
module tb_jam_assign_engine;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    logic start = 1'b0;
    logic max_mode = 1'b0;
    logic [6:0] mat [8][8];

    logic [0:0]  w2, j2;    logic [6:0] c2;  logic b2, v2;   logic [8:0]  m2;  logic [15:0] n2;  logic [1:0]  p2;
    logic [1:0]  w3a, j3a;  logic [6:0] c3a; logic b3a, v3a; logic [9:0]  m3a; logic [15:0] n3a; logic [5:0]  p3a;
    logic [1:0]  w3b, j3b;  logic [6:0] c3b; logic b3b, v3b; logic [9:0]  m3b; logic [15:0] n3b; logic [5:0]  p3b;
    logic [2:0]  w6, j6;    logic [6:0] c6;  logic b6, v6;   logic [10:0] m6;  logic [15:0] n6;  logic [17:0] p6;

    assign c2  = mat[w2][j2];
    assign c3a = mat[w3a][j3a];
    assign c3b = mat[w3b][j3b];
    assign c6  = mat[w6][j6];

    jam_assign_engine #(.N(2), .PRUNE(0)) d2 (.CLK(CLK), .RST(RST), .start(start), .max_mode(max_mode),
        .Cost(c2), .W(w2), .J(j2), .busy(b2), .Valid(v2), .MinCost(m2), .MatchCount(n2), .BestPerm(p2));
    jam_assign_engine #(.N(3), .PRUNE(0)) d3a (.CLK(CLK), .RST(RST), .start(start), .max_mode(max_mode),
        .Cost(c3a), .W(w3a), .J(j3a), .busy(b3a), .Valid(v3a), .MinCost(m3a), .MatchCount(n3a), .BestPerm(p3a));
    jam_assign_engine #(.N(3), .PRUNE(1)) d3b (.CLK(CLK), .RST(RST), .start(start), .max_mode(max_mode),
        .Cost(c3b), .W(w3b), .J(j3b), .busy(b3b), .Valid(v3b), .MinCost(m3b), .MatchCount(n3b), .BestPerm(p3b));
    jam_assign_engine #(.N(6), .PRUNE(1)) d6 (.CLK(CLK), .RST(RST), .start(start), .max_mode(max_mode),
        .Cost(c6), .W(w6), .J(j6), .busy(b6), .Valid(v6), .MinCost(m6), .MatchCount(n6), .BestPerm(p6));

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;
    int wj_bad = 0;
    int lat_g [4];
    int ns [4] = '{2, 3, 3, 6};
    int iws [4] = '{1, 2, 2, 3};
    int prs [4] = '{0, 0, 1, 1};

    logic [3:0]  vld, bsy;
    logic [63:0] omin [4];
    logic [63:0] ocnt [4];
    logic [63:0] obp  [4];

    assign vld = {v6, v3b, v3a, v2};
    assign bsy = {b6, b3b, b3a, b2};

    always_comb begin
        omin[0] = 64'(m2);  omin[1] = 64'(m3a); omin[2] = 64'(m3b); omin[3] = 64'(m6);
        ocnt[0] = 64'(n2);  ocnt[1] = 64'(n3a); ocnt[2] = 64'(n3b); ocnt[3] = 64'(n6);
        obp[0]  = 64'(p2);  obp[1]  = 64'(p3a); obp[2]  = 64'(p3b); obp[3]  = 64'(p6);
    end

    // Request indices must stay inside the matrix of each instance.
    always @(negedge CLK) begin
        if (!RST && (w3a > 2'd2 || j3a > 2'd2 || w3b > 2'd2 || j3b > 2'd2 || w6 > 3'd5 || j6 > 3'd5))
            wj_bad = wj_bad + 1;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks = checks + 1;
        assert (obs === exp) else begin
            errors = errors + 1;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int fact(input int n);
        int f = 1;
        for (int i = 2; i <= n; i++) f = f * i;
        return f;
    endfunction

    function automatic logic [63:0] ident(input int n, input int iw);
        logic [63:0] r = '0;
        for (int i = 0; i < n; i++) r = r | (64'(i) << (i * iw));
        return r;
    endfunction

    // Enumerate every n-digit tuple (worker 0 most significant); the permutations
    // among them appear in lexicographic order.
    function automatic void model(input int n, input int iw, input bit mode,
                                  output logic [63:0] mn, output logic [63:0] cnt, output logic [63:0] bp);
        int total = 1;
        int d [8];
        mn = '0; cnt = '0; bp = '0;
        for (int k = 0; k < n; k++) total = total * n;
        for (int code = 0; code < total; code++) begin
            int tmp = code;
            int s = 0;
            bit ok = 1'b1;
            bit [7:0] used = '0;
            for (int k = n - 1; k >= 0; k--) begin
                d[k] = tmp % n;
                tmp = tmp / n;
            end
            for (int k = 0; k < n; k++) begin
                if (used[d[k]]) ok = 1'b0;
                used[d[k]] = 1'b1;
                s = s + int'(mat[k][d[k]]);
            end
            if (ok) begin
                if (cnt == 0 || (mode ? (64'(s) > mn) : (64'(s) < mn))) begin
                    mn = 64'(s);
                    cnt = 64'd1;
                    bp = '0;
                    for (int k = 0; k < n; k++) bp = bp | (64'(d[k]) << (k * iw));
                end else if (64'(s) == mn) begin
                    cnt = cnt + 64'd1;
                end
            end
        end
    endfunction

    task automatic run(input bit mode, input int extra_at, input bit prune_exact);
        int mx;
        bit alld;
        logic [63:0] emn, ecnt, ebp;
        for (int i = 0; i < 4; i++) lat_g[i] = -1;
        @(negedge CLK);
        start = 1'b1;
        max_mode = mode;
        @(posedge CLK);
        #1 start = 1'b0;
        chk("busy_after_start", 64'(bsy), 64'hF);
        for (int e = 1; e <= 6000; e++) begin
            @(posedge CLK);
            #1;
            if (start) start = 1'b0;
            if (e == extra_at) start = 1'b1;
            for (int i = 0; i < 4; i++) begin
                if (lat_g[i] < 0 && vld[i]) lat_g[i] = e;
                else if (lat_g[i] >= 0 && lat_g[i] == e - 1)
                    chk($sformatf("valid_width_%0d", i), 64'(vld[i]), 64'd0);
            end
            alld = 1'b1;
            mx = 0;
            for (int i = 0; i < 4; i++) begin
                if (lat_g[i] < 0) alld = 1'b0;
                if (lat_g[i] > mx) mx = lat_g[i];
            end
            if (alld && e > mx) break;
        end
        for (int i = 0; i < 4; i++) begin
            int el;
            model(ns[i], iws[i], mode, emn, ecnt, ebp);
            el = fact(ns[i]) * (ns[i] + 2) - 1;
            chk($sformatf("min_%0d", i), omin[i], emn);
            chk($sformatf("count_%0d", i), ocnt[i], ecnt);
            chk($sformatf("bestperm_%0d", i), obp[i], ebp);
            chk($sformatf("busy_end_%0d", i), 64'(bsy[i]), 64'd0);
            if (prs[i] == 0 || mode || prune_exact)
                chk($sformatf("latency_%0d", i), 64'(lat_g[i]), 64'(el));
            else
                chk($sformatf("latency_le_%0d", i), 64'(lat_g[i] > 0 && lat_g[i] <= el), 64'd1);
        end
    endtask

    task automatic set_t2;
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++) mat[r][c] = 7'd0;
        mat[0][0] = 7'd4; mat[0][1] = 7'd1; mat[0][2] = 7'd3;
        mat[1][0] = 7'd2; mat[1][1] = 7'd0; mat[1][2] = 7'd5;
        mat[2][0] = 7'd3; mat[2][1] = 7'd2; mat[2][2] = 7'd2;
    endtask

    initial begin
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++) mat[r][c] = 7'd0;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        RST = 1'b0;
        #1;
        chk("rst_busy", 64'(bsy), 64'd0);
        chk("rst_valid", 64'(vld), 64'd0);
        chk("rst_min3", 64'(m3a), 64'h3FF);
        chk("rst_cnt3", 64'(n3a), 64'd0);
        chk("rst_bp3", 64'(p3a), ident(3, 2));
        chk("rst_wj3", 64'({w3a, j3a}), 64'd0);

        // Two workers, every permutation ties at 5.
        mat[0][0] = 7'd1; mat[0][1] = 7'd2; mat[1][0] = 7'd3; mat[1][1] = 7'd4;
        run(1'b0, -1, 1'b0);
        chk("t1_min", 64'(m2), 64'd5);
        chk("t1_cnt", 64'(n2), 64'd2);
        chk("t1_bp", 64'(p2), 64'd2);
        chk("t1_lat", 64'(lat_g[0]), 64'd7);

        set_t2();
        run(1'b0, -1, 1'b0);
        chk("t2_min", 64'(m3a), 64'd5);
        chk("t2_cnt", 64'(n3a), 64'd1);
        chk("t2_bp", 64'(p3a), 64'd33);
        chk("t2_lat", 64'(lat_g[1]), 64'd29);
        chk("t4_same_min", 64'(m3b), 64'd5);
        chk("t4_same_bp", 64'(p3b), 64'd33);
        chk("t4_earlier", 64'(lat_g[2] > 0 && lat_g[2] < 29), 64'd1);

        run(1'b1, -1, 1'b0);
        chk("t3_min", 64'(m3a), 64'd11);
        chk("t3_cnt", 64'(n3a), 64'd1);
        chk("t3_bp", 64'(p3a), 64'd24);
        chk("t3_bp_prune", 64'(p3b), 64'd24);

        // Uniform costs, with a start pulse mid-run that must be ignored.
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++) mat[r][c] = 7'd7;
        run(1'b0, 3, 1'b1);
        chk("t5_min", 64'(m6), 64'd42);
        chk("t5_cnt", 64'(n6), 64'd720);
        chk("t5_bp", 64'(p6), ident(6, 3));
        chk("t5_lat", 64'(lat_g[3]), 64'd5759);

        for (int t = 0; t < 5; t++) begin
            for (int r = 0; r < 8; r++)
                for (int c = 0; c < 8; c++) mat[r][c] = 7'($urandom_range(0, 127));
            if (t == 4)
                for (int r = 0; r < 8; r++)
                    for (int c = 0; c < 8; c++) mat[r][c] = 7'($urandom_range(0, 1));
            run(1'($urandom_range(0, 1)), -1, 1'b0);
        end

        // Reset in the middle of the third permutation's load.
        set_t2();
        @(negedge CLK);
        start = 1'b1;
        max_mode = 1'b0;
        @(posedge CLK);
        #1 start = 1'b0;
        repeat (11) @(posedge CLK);
        #1 RST = 1'b1;
        #1;
        chk("t6_busy", 64'(bsy), 64'd0);
        chk("t6_valid", 64'(vld), 64'd0);
        chk("t6_min", 64'(m3a), 64'h3FF);
        chk("t6_cnt", 64'(n3a), 64'd0);
        chk("t6_bp", 64'(p3a), ident(3, 2));
        chk("t6_wj", 64'({w3a, j3a}), 64'd0);
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        RST = 1'b0;
        for (int e = 0; e < 4; e++) begin
            @(posedge CLK);
            #1 chk("t6_no_valid", 64'(vld), 64'd0);
        end
        run(1'b0, -1, 1'b0);
        chk("t6_min_again", 64'(m3a), 64'd5);
        chk("t6_cnt_again", 64'(n3a), 64'd1);
        chk("t6_bp_again", 64'(p3a), 64'd33);
        chk("t6_lat_again", 64'(lat_g[1]), 64'd29);

        chk("wj_range", 64'(wj_bad), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
